usbfs_packet_rx: RTL and testbench

- Receive-side packet layer of the USB full-speed device core.
- Sits between the bit-level receiver (NRZI decode, bit unstuff, SYNC/EOP detect) and the transaction controller.
- Input: a byte stream with start and end markers. Output: the rp_* packet interface.
- Validates the PID, extracts the token address/endpoint, checks CRC5/CRC16, strips the CRC bytes from data payloads, and flags each packet okay or bad at its end.

---
 rtl/usbfs_pkg.sv | 44 ++++
 rtl/usbfs_crc_byte.sv | 28 ++
 rtl/usbfs_packet_rx.sv | 199 +++++++++++++++++++
 tb/tb_usbfs_packet_rx.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usbfs_pkg.sv
// Shared definitions for the USB full-speed device core packet layers.
//   - PID values (4-bit, the low nibble of the PID byte on the wire)
//   - CRC5 / CRC16 polynomials (reflected, LSB-first), seeds and good residuals
//   - Receive packet FSM state type
//   - pid_check(): PID byte integrity test (high nibble is the complement of low)
package usbfs_pkg;

  // Token PIDs
  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_SOF   = 4'h5;
  // Data PIDs
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  // Handshake PIDs
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  // CRC5 covers the 11-bit token field plus its own 5 bits.
  localparam logic [4:0]  CRC5_POLY      = 5'h14;
  localparam logic [4:0]  CRC5_INIT      = 5'h1F;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'h06;

  // CRC16 covers the data payload plus its own 2 bytes.
  localparam logic [15:0] CRC16_POLY     = 16'hA001;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_TOKEN,
    ST_DATA,
    ST_HSHK,
    ST_ERR
  } rx_state_e;

  function automatic logic pid_check(input logic [7:0] pid_byte);
    return pid_byte[7:4] == ~pid_byte[3:0];
  endfunction

endpackage

// File: rtl/usbfs_crc_byte.sv
// One-byte LSB-first CRC update for a reflected polynomial.
// Purely combinational: the caller holds the CRC register.
//   crc_in  [WIDTH-1:0]  current CRC value
//   data    [7:0]        byte to absorb, bit 0 is processed first
//   crc_out [WIDTH-1:0]  CRC after absorbing all 8 bits
module usbfs_crc_byte #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = 16'hA001
) (
  input  logic [WIDTH-1:0] crc_in,
  input  logic [7:0]       data,
  output logic [WIDTH-1:0] crc_out
);

  always_comb begin
    logic [WIDTH-1:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ POLY;
      end else begin
        c = c >> 1;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/usbfs_packet_rx.sv
// Receive packet layer of the USB full-speed device core.
// Turns the byte stream from the bit-level receiver into packets:
// checks the PID, extracts the token field, checks CRC5/CRC16, strips the
// trailing CRC16 bytes from data payloads and reports okay/bad at the end.
//
// Input strobes: rx_sta, rx_byte_en and rx_fin are single-cycle qualifiers
// with no back-pressure; a byte is consumed in the cycle rx_byte_en is high.
// rx_sta takes priority over everything and restarts packet parsing.
// Output strobes: rp_byte_en and rp_fin are single-cycle and must be taken
// when high; rp_okay only has meaning while rp_fin is high (0 otherwise).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rx_sta            SYNC detected, a new packet begins
//   rx_byte_en/rx_byte received byte strobe and data (LSB first on the wire)
//   rx_fin            EOP seen
//   rp_pid            PID of the current/last packet
//   rp_addr           token field {ENDP, ADDR}
//   rp_byte_en/rp_byte payload byte strobe and data (CRC16 bytes excluded)
//   rp_fin/rp_okay    end-of-packet pulse and its good/bad qualifier
module usbfs_packet_rx
  import usbfs_pkg::*;
#(
  parameter logic [9:0] DATA_MAXLEN = 10'd1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_sta,
  input  logic        rx_byte_en,
  input  logic [7:0]  rx_byte,
  input  logic        rx_fin,
  output logic [3:0]  rp_pid,
  output logic [10:0] rp_addr,
  output logic        rp_byte_en,
  output logic [7:0]  rp_byte,
  output logic        rp_fin,
  output logic        rp_okay
);

  rx_state_e   state;
  rx_state_e   state_next;

  logic [4:0]  crc5;
  logic [4:0]  crc5_upd;
  logic [15:0] crc16;
  logic [15:0] crc16_upd;
  logic [10:0] byte_cnt;   // data bytes after the PID, CRC included
  logic [1:0]  tok_cnt;    // token bytes after the PID
  logic [7:0]  tok_lo;     // first token byte, held until the second arrives
  logic [7:0]  dly_new;    // most recent data byte
  logic [7:0]  dly_old;    // data byte before that
  logic        data_ok;
  logic        fin_okay;

  usbfs_crc_byte #(
    .WIDTH (5),
    .POLY  (CRC5_POLY)
  ) u_crc5 (
    .crc_in  (crc5),
    .data    (rx_byte),
    .crc_out (crc5_upd)
  );

  usbfs_crc_byte #(
    .WIDTH (16),
    .POLY  (CRC16_POLY)
  ) u_crc16 (
    .crc_in  (crc16),
    .data    (rx_byte),
    .crc_out (crc16_upd)
  );

  // byte_cnt includes the two CRC bytes, so the payload limit is MAXLEN+2.
  // The counter saturates well above any legal limit, so a saturated count
  // always fails the length test.
  assign data_ok = (byte_cnt >= 11'd2) &&
                   (crc16 == CRC16_RESIDUAL) &&
                   ({1'b0, byte_cnt} <= ({2'b00, DATA_MAXLEN} + 12'd2));

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next state and end-of-packet verdict
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    fin_okay   = 1'b0;
    if (rx_sta) begin
      state_next = ST_PID;
    end else if (rx_fin) begin
      state_next = ST_IDLE;
      case (state)
        ST_TOKEN: fin_okay = (tok_cnt == 2'd2) && (crc5 == CRC5_RESIDUAL);
        ST_DATA:  fin_okay = data_ok;
        ST_HSHK:  fin_okay = 1'b1;
        default:  fin_okay = 1'b0;
      endcase
    end else if (rx_byte_en) begin
      case (state)
        ST_PID: begin
          if (!pid_check(rx_byte)) begin
            state_next = ST_ERR;
          end else begin
            case (rx_byte[3:0])
              PID_OUT, PID_IN, PID_SETUP, PID_SOF: state_next = ST_TOKEN;
              PID_DATA0, PID_DATA1:                state_next = ST_DATA;
              PID_ACK, PID_NAK, PID_STALL:         state_next = ST_HSHK;
              default:                             state_next = ST_ERR;
            endcase
          end
        end
        ST_TOKEN: begin
          if (tok_cnt == 2'd2) state_next = ST_ERR;
        end
        ST_HSHK:  state_next = ST_ERR;
        default:  state_next = state;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Datapath: CRCs, counters, delay line and registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc5       <= '0;
      crc16      <= '0;
      byte_cnt   <= '0;
      tok_cnt    <= '0;
      tok_lo     <= '0;
      dly_new    <= '0;
      dly_old    <= '0;
      rp_pid     <= '0;
      rp_addr    <= '0;
      rp_byte_en <= 1'b0;
      rp_byte    <= '0;
      rp_fin     <= 1'b0;
      rp_okay    <= 1'b0;
    end else begin
      rp_byte_en <= 1'b0;
      rp_fin     <= 1'b0;
      rp_okay    <= 1'b0;
      if (rx_sta) begin
        crc5     <= CRC5_INIT;
        crc16    <= CRC16_INIT;
        byte_cnt <= '0;
        tok_cnt  <= '0;
      end else if (rx_fin) begin
        rp_fin  <= 1'b1;
        rp_okay <= fin_okay;
      end else if (rx_byte_en) begin
        case (state)
          ST_PID: begin
            rp_pid   <= rx_byte[3:0];
            crc5     <= CRC5_INIT;
            crc16    <= CRC16_INIT;
            byte_cnt <= '0;
            tok_cnt  <= '0;
          end
          ST_TOKEN: begin
            // A third byte sends the FSM to ERR; the field is left as is.
            if (tok_cnt != 2'd2) begin
              crc5    <= crc5_upd;
              tok_cnt <= tok_cnt + 2'd1;
              if (tok_cnt == 2'd0) begin
                tok_lo <= rx_byte;
              end else begin
                rp_addr <= {rx_byte[2:0], tok_lo};
              end
            end
          end
          ST_DATA: begin
            crc16 <= crc16_upd;
            if (byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
            // The last two bytes of any data packet are its CRC, so a byte
            // is only known to be payload once two more have followed it.
            if (byte_cnt >= 11'd2) begin
              rp_byte_en <= 1'b1;
              rp_byte    <= dly_old;
            end
            dly_old <= dly_new;
            dly_new <= rx_byte;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usbfs_packet_rx.sv
// Directed and randomized checks of usbfs_packet_rx against a packet-level
// reference model. Two instances share the input stream: one with the
// default payload limit and one with a limit of 4 bytes.
module tb_usbfs_packet_rx;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic        rx_sta;
  logic        rx_byte_en;
  logic [7:0]  rx_byte;
  logic        rx_fin;

  logic [3:0]  rp_pid;
  logic [10:0] rp_addr;
  logic        rp_byte_en;
  logic [7:0]  rp_byte;
  logic        rp_fin;
  logic        rp_okay;

  logic [3:0]  s_rp_pid;
  logic [10:0] s_rp_addr;
  logic        s_rp_byte_en;
  logic [7:0]  s_rp_byte;
  logic        s_rp_fin;
  logic        s_rp_okay;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  usbfs_packet_rx dut (
    .clk        (clk),
    .rst        (rst),
    .rx_sta     (rx_sta),
    .rx_byte_en (rx_byte_en),
    .rx_byte    (rx_byte),
    .rx_fin     (rx_fin),
    .rp_pid     (rp_pid),
    .rp_addr    (rp_addr),
    .rp_byte_en (rp_byte_en),
    .rp_byte    (rp_byte),
    .rp_fin     (rp_fin),
    .rp_okay    (rp_okay)
  );

  usbfs_packet_rx #(.DATA_MAXLEN(10'd4)) dut_small (
    .clk        (clk),
    .rst        (rst),
    .rx_sta     (rx_sta),
    .rx_byte_en (rx_byte_en),
    .rx_byte    (rx_byte),
    .rx_fin     (rx_fin),
    .rp_pid     (s_rp_pid),
    .rp_addr    (s_rp_addr),
    .rp_byte_en (s_rp_byte_en),
    .rp_byte    (s_rp_byte),
    .rp_fin     (s_rp_fin),
    .rp_okay    (s_rp_okay)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [7:0]  pkt_q[$];   // packet bytes as sent, PID first
  logic [7:0]  exp_q[$];   // expected payload bytes
  logic [7:0]  got_q[$];   // payload bytes seen on rp_byte_*
  logic [3:0]  exp_pid   = 4'h0;
  logic [10:0] exp_addr  = 11'h0;
  logic        pid_known = 1'b1;

  int          fin_cnt  = 0;
  int          fin2_cnt = 0;
  logic        fin_okay;
  logic        fin2_okay;
  logic [3:0]  fin_pid;
  logic [10:0] fin_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rp_byte_en) got_q.push_back(rp_byte);
      if (rp_fin) begin
        fin_cnt++;
        fin_okay = rp_okay;
        fin_pid  = rp_pid;
        fin_addr = rp_addr;
      end else begin
        total++;
        assert (rp_okay === 1'b0) else begin
          bad++;
          $error("FAIL okay_without_fin: observed=%0b expected=0", rp_okay);
        end
      end
      if (s_rp_fin) begin
        fin2_cnt++;
        fin2_okay = s_rp_okay;
      end
    end
  end

  // ---------------- reference model ----------------
  // Serial LSB-first CRC over pkt_q[first..last]; widths up to 16 bits.
  function automatic logic [15:0] crc_run(input logic [15:0] poly, input logic [15:0] init,
                                          input int first, input int last);
    logic [15:0] c;
    c = init;
    for (int i = first; i <= last; i++) begin
      for (int b = 0; b < 8; b++) begin
        logic fb;
        fb = c[0] ^ pkt_q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ poly;
      end
    end
    return c;
  endfunction

  task automatic model(input int maxlen, output logic ok);
    int n;
    logic [7:0] p;
    n = pkt_q.size();
    exp_q = {};
    ok = 1'b0;
    if (n == 0) return;
    p = pkt_q[0];
    exp_pid = p[3:0];
    pid_known = (p[7:4] == ~p[3:0]);
    if (!pid_known) return;
    case (p[3:0])
      4'h1, 4'h9, 4'hD, 4'h5: begin
        if (n >= 3) exp_addr = {pkt_q[2][2:0], pkt_q[1]};
        ok = (n == 3) && (crc_run(16'h0014, 16'h001F, 1, 2) == 16'h0006);
      end
      4'h3, 4'hB: begin
        ok = (n >= 3) && (crc_run(16'hA001, 16'hFFFF, 1, n - 1) == 16'hB001) && (n - 3 <= maxlen);
        for (int i = 1; i <= n - 3; i++) exp_q.push_back(pkt_q[i]);
      end
      4'h2, 4'hA, 4'hE: ok = (n == 1);
      default: ok = 1'b0;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sta();
    rx_sta = 1'b1;
    step();
    rx_sta = 1'b0;
  endtask

  task automatic pulse_fin();
    rx_fin = 1'b1;
    step();
    rx_fin = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte_en = 1'b1;
    rx_byte    = b;
    step();
    rx_byte_en = 1'b0;
    repeat ($urandom_range(0, 2)) step();
  endtask

  task automatic build_token(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp);
    logic [10:0] f;
    f = {endp, addr};
    pkt_q = {};
    pkt_q.push_back({~pid, pid});
    pkt_q.push_back(f[7:0]);
    pkt_q.push_back({5'h00, f[10:8]});
    for (int h = 0; h < 32; h++) begin
      logic [4:0] hi;
      hi = h[4:0];
      pkt_q[2] = {hi, f[10:8]};
      if (crc_run(16'h0014, 16'h001F, 1, 2) == 16'h0006) break;
    end
  endtask

  task automatic build_data(input logic [3:0] pid, input int len);
    logic [15:0] c;
    pkt_q = {};
    pkt_q.push_back({~pid, pid});
    for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
    c = ~crc_run(16'hA001, 16'hFFFF, 1, len);
    pkt_q.push_back(c[7:0]);
    pkt_q.push_back(c[15:8]);
  endtask

  task automatic corrupt();
    int idx;
    idx = $urandom_range(0, pkt_q.size() - 1);
    pkt_q[idx] = pkt_q[idx] ^ (8'h01 << $urandom_range(0, 7));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pid"},     32'(rp_pid),     32'h0);
    check({tag, "_addr"},    32'(rp_addr),    32'h0);
    check({tag, "_byte"},    32'(rp_byte),    32'h0);
    check({tag, "_byte_en"}, 32'(rp_byte_en), 32'h0);
    check({tag, "_fin"},     32'(rp_fin),     32'h0);
    check({tag, "_okay"},    32'(rp_okay),    32'h0);
  endtask

  // Sends pkt_q (optionally preceded by rx_sta), then checks the result.
  task automatic run_pkt(input string tag, input bit with_sta);
    int   start;
    int   start2;
    logic ok;
    logic ok2;
    repeat (2) step();
    got_q  = {};
    start  = fin_cnt;
    start2 = fin2_cnt;
    model(4, ok2);
    model(1023, ok);
    if (with_sta) pulse_sta();
    foreach (pkt_q[i]) send_byte(pkt_q[i]);
    pulse_fin();
    for (int i = 0; i < 10; i++) begin
      if (fin_cnt > start && fin2_cnt > start2) break;
      step();
    end
    check({tag, "_fin_count"},  32'(fin_cnt - start),   32'd1);
    check({tag, "_fin2_count"}, 32'(fin2_cnt - start2), 32'd1);
    check({tag, "_okay"},       32'(fin_okay),  32'(ok));
    check({tag, "_okay_small"}, 32'(fin2_okay), 32'(ok2));
    if (pid_known) check({tag, "_pid"}, 32'(fin_pid), 32'(exp_pid));
    check({tag, "_addr"},       32'(fin_addr),  32'(exp_addr));
    check({tag, "_payload_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_payload_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] setup_bytes[11] = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00,
                                  8'h00, 8'h12, 8'h00, 8'hE0, 8'hF4};
  logic [3:0] tok_pids[4] = '{4'h1, 4'h9, 4'hD, 4'h5};
  logic [3:0] hs_pids[3]  = '{4'h2, 4'hA, 4'hE};

  initial begin
    int start;
    rst = 1'b1;
    rx_sta = 1'b0;
    rx_byte_en = 1'b0;
    rx_byte = 8'h00;
    rx_fin = 1'b0;
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    step();

    // IN token addr 0 endp 1, then with a corrupted CRC byte
    pkt_q = {8'h69, 8'h80, 8'hA0};
    run_pkt("in_token", 1'b1);
    check("in_token_addr_const", 32'(rp_addr), 32'h080);
    pkt_q = {8'h69, 8'h80, 8'hA1};
    run_pkt("in_token_bad", 1'b1);
    check("in_token_bad_pid", 32'(rp_pid), 32'h9);

    // GetDescriptor setup data
    pkt_q = {};
    foreach (setup_bytes[i]) pkt_q.push_back(setup_bytes[i]);
    run_pkt("setup_data", 1'b1);

    // Zero-length DATA1, good and with a bad PID byte
    pkt_q = {8'h4B, 8'h00, 8'h00};
    run_pkt("zlp", 1'b1);
    pkt_q = {8'h4C, 8'h00, 8'h00};
    run_pkt("zlp_badpid", 1'b1);

    // Handshakes
    pkt_q = {8'hD2};
    run_pkt("ack", 1'b1);
    pkt_q = {8'hD2, 8'h00};
    run_pkt("ack_extra", 1'b1);

    // EOP with no SYNC, SYNC then EOP, and a 1-byte data packet
    pkt_q = {};
    run_pkt("fin_idle", 1'b0);
    run_pkt("fin_pid", 1'b1);
    pkt_q = {8'hC3, 8'h55};
    run_pkt("data_1byte", 1'b1);

    // rx_sta reissued mid-DATA, then a clean token: one rp_fin only
    start = fin_cnt;
    pulse_sta();
    send_byte(8'hC3);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    build_token(4'h1, 7'h2A, 4'h5);
    run_pkt("restart_token", 1'b1);
    check("restart_total_fins", 32'(fin_cnt - start), 32'd1);

    // Reset in the middle of a DATA packet
    start = fin_cnt;
    pulse_sta();
    send_byte(8'hC3);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    rst = 1'b1;
    #1;
    check_zero("mid_rst");
    step();
    check_zero("mid_rst_hold");
    rst = 1'b0;
    repeat (5) step();
    check_zero("after_rst");
    check("after_rst_no_fin", 32'(fin_cnt - start), 32'd0);
    exp_pid = 4'h0;
    exp_addr = 11'h0;
    pid_known = 1'b1;

    // Payload length boundary for the small instance (limit 4)
    build_data(4'h3, 5);
    run_pkt("len5", 1'b1);
    build_data(4'hB, 4);
    run_pkt("len4", 1'b1);

    // Randomized packets
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 4))
        0: begin
          build_token(tok_pids[$urandom_range(0, 3)], 7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)));
          if ($urandom_range(0, 3) == 0) corrupt();
        end
        1: begin
          build_data($urandom_range(0, 1) ? 4'h3 : 4'hB, $urandom_range(0, 8));
          if ($urandom_range(0, 3) == 0) corrupt();
        end
        2: begin
          pkt_q = {};
          pkt_q.push_back({~hs_pids[$urandom_range(0, 2)], 4'h0});
          pkt_q[0][3:0] = ~pkt_q[0][7:4];
          if ($urandom_range(0, 2) == 0) pkt_q.push_back(8'($urandom_range(0, 255)));
        end
        3: begin
          pkt_q = {};
          repeat ($urandom_range(1, 4)) pkt_q.push_back(8'($urandom_range(0, 255)));
        end
        default: build_data(4'h3, $urandom_range(3, 6));
      endcase
      run_pkt("random", 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
